decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  Pipelined RV32IM + Zicsr instruction decoder; producer of the `instructions` record that the execute stage consumes.
//  Accepts {pc, raw 32-bit word} from fetch over valid/ready, emits one-hot op flags, imm, zimm and register indices.
//  Sits between fetch and the register-read/execute stage; 2-entry skid buffer gives fully registered in_ready/out_valid.
// PARAMETERS
//  XLEN        32   data/imm width; only 32 supported
//  CHECK_ZERO  1    1: opcode 0x00000000 and 0xFFFFFFFF flagged illegal
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      fetch word valid
//  in_ready    out  1      stage can accept; registered
//  in_pc       in   32     pc of word, passed through unchanged
//  in_word     in   32     raw instruction
//  flush       in   1      discard all held entries (branch/trap redirect)
//  out_valid   out  1      decoded entry valid; registered
//  out_ready   in   1      downstream accepts
//  out_instr   out  struct instructions: op flags, pc, imm, zimm
//  out_rs1     out  5      rs1 index (0 when format has no rs1)
//  out_rs2     out  5      rs2 index (0 when format has no rs2)
//  out_rd      out  5      rd index
//  out_rd_we   out  1      writes rd AND rd!=0
//  out_illegal out  1      no op flag matched; all flags 0
// BEHAVIOUR
//  Reset (rst=1 at posedge): out_valid=0, skid empty, in_ready=1 next cycle, out_instr/indices/flags all 0.
//  Handshake: transfer on valid&&ready. out_valid never drops without out_ready; payload stable while stalled.
//  Latency: 1 cycle in->out when downstream ready; throughput 1/cycle sustained.
//  Skid: out_reg + skid_reg. in_ready = !skid_valid. Accept while out_reg full && !out_ready -> word to skid.
//   On out fire: skid (if valid) moves to out_reg, else new input, else out_valid=0. Order strictly FIFO.
//   Simultaneous in fire + out fire with skid empty: new entry replaces out_reg same edge.
//  Flush: same edge clears out_valid and skid_valid; input presented that cycle dropped; in_ready=1 next cycle.
//   flush has priority over in fire; rst has priority over flush.
//  Decode (combinational, registered at out_reg entry):
//   exactly one op flag set per legal word; funct3/funct7/opcode fully checked (e.g. funct7=0x20 only for sub/sra/srai).
//   imm sign-extended to 32: I(addi..,loads,jalr), S, B, U (imm[11:0]=0), J; shamt in imm[4:0] for slli/srli/srai.
//   csr*: imm[11:0]=csr address, zero-extended; zimm = {27'b0, word[19:15]}.
//   branches/stores: out_rd_we=0; fence/ecall/ebreak: out_rd_we=0, rs indices 0.
//  Illegal: out_illegal=1, flags/imm 0, out_rd_we=0; entry still flows through handshake (trap handled downstream).
//  Mid-operation reset: entries discarded, no partial output.
// STRUCTURE
//  def.sv (shared package): `instructions` struct, OPC_* opcode, F3_*/F7_* constants, imm-format enum.
//  Sub-module instr_decode (pure combinational word,pc -> record); decode_stage owns skid/handshake only.
//  Decode applied at input side so skid holds decoded records.
// TESTING
//  addi x1,x2,-1 (0xFFF10093) -> addi=1, imm=0xFFFFFFFF, rs1=2, rd=1, rd_we=1, out_valid next cycle.
//  lui x5,0x12345 (0x123452B7) -> lui=1, imm=0x12345000, rd=5; jal x1,-4 (0xFFDFF0EF) -> imm=0xFFFFFFFC.
//  out_ready=0 for 3 cycles, 3 words offered -> in_ready low after 2nd accept; release -> all 3 out in order, none lost.
//  flush with out+skid full and in_valid=1 -> out_valid=0 next cycle, in_ready=1, flushed word never emitted.
//  0x00000000 and sub with funct7=0x01 (0x022081B3 is mul; use 0x062081B3) -> illegal=1, rd_we=0.
//  csrrsi x3,0x300,7 (0x3003E1F3) -> csrrsi=1, imm=0x300, zimm=7; random stall/valid soak vs reference model.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared opcode constants, op enum and decoded-record types
package decode_stage_pkg;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_PRIV = 3'b000;
  // Groups decoded by funct3 are laid out so that base + offset lands on the right op
  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLLI, OP_SLTI, OP_SLTIU, OP_XORI, OP_SRLI, OP_ORI, OP_ANDI, OP_SRAI,
    OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND, OP_SUB, OP_SRA,
    OP_FENCE, OP_ECALL, OP_EBREAK,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI
  } op_e;
  localparam int OP_N = 54;
  typedef enum logic [3:0] {
    FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_SH, FMT_CSR, FMT_CSRI
  } fmt_e;
  typedef struct packed {
    logic [OP_N-1:0] op;
    logic [31:0]     pc;
    logic [31:0]     imm;
    logic [31:0]     zimm;
  } instructions;
  typedef struct packed {
    instructions instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } decoded_t;
  function automatic op_e op_at(op_e base, logic [2:0] off);
    return op_e'(6'(base) + 6'(off));
  endfunction
endpackage

// File: rtl/decode_stage_instr_decode.sv
// instr_decode: combinational RV32IM+Zicsr word decoder producing a decoded record
module instr_decode
  import decode_stage_pkg::*;
#(
  parameter bit CHECK_ZERO = 1'b1
) (
  input  logic [31:0] word,
  input  logic [31:0] pc,
  output decoded_t    dec
);
  localparam logic [OP_N-1:0] OP_ONE = 1;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  op_e op;
  fmt_e fmt, f;
  logic ok, legal;
  assign opc = word[6:0];
  assign f3 = word[14:12];
  assign f7 = word[31:25];
  // Classify the word into one op plus its operand format; ok only on an exact encoding match
  always_comb begin
    op = OP_ADDI;
    fmt = FMT_NONE;
    ok = 1'b0;
    case (opc)
      OPC_LUI: begin op = OP_LUI; fmt = FMT_U; ok = 1'b1; end
      OPC_AUIPC: begin op = OP_AUIPC; fmt = FMT_U; ok = 1'b1; end
      OPC_JAL: begin op = OP_JAL; fmt = FMT_J; ok = 1'b1; end
      OPC_JALR: begin op = OP_JALR; fmt = FMT_I; ok = f3 == 3'b000; end
      OPC_BRANCH: begin op = op_at(OP_BEQ, f3 - {1'b0, f3[2], 1'b0}); fmt = FMT_B; ok = f3[2:1] != 2'b01; end
      OPC_LOAD: begin op = op_at(OP_LB, f3 - {2'b0, f3[2]}); fmt = FMT_I; ok = !f3[1] || f3 == 3'b010; end
      OPC_STORE: begin op = op_at(OP_SB, f3); fmt = FMT_S; ok = f3 < 3'd3; end
      OPC_OP_IMM: begin
        op = (f3 == F3_SR && f7 == F7_ALT) ? OP_SRAI : op_at(OP_ADDI, f3);
        fmt = (f3 == F3_SLL || f3 == F3_SR) ? FMT_SH : FMT_I;
        ok = f3 == F3_SLL ? f7 == F7_BASE : f3 == F3_SR ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
      end
      OPC_OP: begin
        op = f7 == F7_MULDIV ? op_at(OP_MUL, f3) : f7 == F7_ALT ? (f3 == F3_SR ? OP_SRA : OP_SUB) : op_at(OP_ADD, f3);
        fmt = FMT_R;
        ok = f7 == F7_BASE || f7 == F7_MULDIV || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
      end
      OPC_MISC_MEM: begin op = OP_FENCE; ok = f3 == 3'b000; end
      OPC_SYSTEM: begin
        op = f3 == F3_PRIV ? (word[20] ? OP_EBREAK : OP_ECALL) : op_at(OP_CSRRW, f3 - 3'd1 - {2'b0, f3[2]});
        fmt = f3 == F3_PRIV ? FMT_NONE : f3[2] ? FMT_CSRI : FMT_CSR;
        ok = f3 == F3_PRIV ? (word == 32'h0000_0073 || word == 32'h0010_0073) : f3 != 3'b100;
      end
      default: ;
    endcase
  end
  assign legal = ok && !(CHECK_ZERO && (word == 32'h0 || &word));
  assign f = legal ? fmt : FMT_NONE;
  assign dec.instr.op = legal ? OP_ONE << op : '0;
  assign dec.instr.pc = pc;
  assign dec.instr.imm =
    f == FMT_I  ? {{20{word[31]}}, word[31:20]} :
    f == FMT_S  ? {{20{word[31]}}, word[31:25], word[11:7]} :
    f == FMT_B  ? {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0} :
    f == FMT_U  ? {word[31:12], 12'b0} :
    f == FMT_J  ? {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0} :
    f == FMT_SH ? {27'b0, word[24:20]} :
    (f == FMT_CSR || f == FMT_CSRI) ? {20'b0, word[31:20]} : '0;
  assign dec.instr.zimm = (f == FMT_CSR || f == FMT_CSRI) ? {27'b0, word[19:15]} : '0;
  assign dec.rs1 = f inside {FMT_I, FMT_S, FMT_B, FMT_R, FMT_SH, FMT_CSR} ? word[19:15] : '0;
  assign dec.rs2 = f inside {FMT_S, FMT_B, FMT_R} ? word[24:20] : '0;
  assign dec.rd = f inside {FMT_I, FMT_U, FMT_J, FMT_R, FMT_SH, FMT_CSR, FMT_CSRI} ? word[11:7] : '0;
  assign dec.rd_we = dec.rd != 5'd0;
  assign dec.illegal = !legal;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode at the input and hold decoded records in a 2-entry skid buffer
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit CHECK_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output instructions     out_instr,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_illegal
);
  decoded_t dec, out_reg, skid_reg;
  logic skid_valid, in_fire, out_en;
  instr_decode #(.CHECK_ZERO(CHECK_ZERO)) u_dec (.word(in_word), .pc(in_pc), .dec(dec));
  assign in_ready = !skid_valid;
  assign in_fire = in_valid && in_ready;
  assign out_en = out_ready || !out_valid;
  // Output slot refills from skid first, then from input; a stalled output diverts input to skid
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_reg <= '0;
      skid_reg <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_en) begin
      out_valid <= skid_valid || in_fire;
      skid_valid <= 1'b0;
      if (skid_valid) out_reg <= skid_reg;
      else if (in_fire) out_reg <= dec;
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_reg <= dec;
    end
  end
  assign out_instr = out_reg.instr;
  assign out_rs1 = out_reg.rs1;
  assign out_rs2 = out_reg.rs2;
  assign out_rd = out_reg.rd;
  assign out_rd_we = out_reg.rd_we;
  assign out_illegal = out_reg.illegal;
endmodule
